// File: rtl/fetch_pc_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_if
//  Description : Bundle between the fetch front end (fetcher, decoders,
//                branch predictor, ROB flush) and the fetch PC unit.
//                master = front-end side, slave = fetch_pc_unit side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_if #(
    parameter int WIDTH       = 32,
    parameter int FETCH_WIDTH = 2,
    parameter int CNT_WIDTH   = 16
);
    localparam int c_ENQ_W = $clog2(FETCH_WIDTH + 1);

    // Front end -> PC unit
    logic                         fetch_rdy;
    logic                         iq_full;
    logic [FETCH_WIDTH-1:0]       lane_is_jal;
    logic [FETCH_WIDTH-1:0]       lane_is_br;
    logic [FETCH_WIDTH-1:0]       lane_pred_taken;
    logic [FETCH_WIDTH*WIDTH-1:0] lane_target;
    logic                         flush_valid;
    logic [WIDTH-1:0]             flush_pc;

    // PC unit -> front end / instruction queue
    logic [WIDTH-1:0]             pc_out;
    logic                         pc_load;
    logic                         enq_valid;
    logic [c_ENQ_W-1:0]           enq_count;
    logic                         redirect_pend;
    logic [CNT_WIDTH-1:0]         redirect_cnt;
    logic [CNT_WIDTH-1:0]         flush_cnt;

    modport master (
        output fetch_rdy, iq_full, lane_is_jal, lane_is_br, lane_pred_taken,
               lane_target, flush_valid, flush_pc,
        input  pc_out, pc_load, enq_valid, enq_count, redirect_pend,
               redirect_cnt, flush_cnt
    );

    modport slave (
        input  fetch_rdy, iq_full, lane_is_jal, lane_is_br, lane_pred_taken,
               lane_target, flush_valid, flush_pc,
        output pc_out, pc_load, enq_valid, enq_count, redirect_pend,
               redirect_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_unit
//  Description : Next-PC generator and fetch-group gate for an N-wide front
//                end. Chooses between sequential fetch, the first predicted
//                taken branch/jal, a ROB flush or a latched pending flush,
//                and tells the instruction queue how many lanes to enqueue.
//                Interface parameters must match the module parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter int               WIDTH       = 32,
    parameter int               FETCH_WIDTH = 2,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(32'h60),
    parameter int               CNT_WIDTH   = 16
) (
    input  logic     clk,
    input  logic     rst,       // asynchronous, active-low
    fetch_pc_if.slave bus
);
    localparam int               c_ENQ_W   = $clog2(FETCH_WIDTH + 1);
    localparam logic [WIDTH-1:0] c_PC_STEP = WIDTH'(4 * FETCH_WIDTH);

    // Fetch state: RUN fetches normally, HOLD waits to apply a latched flush
    localparam logic [0:0] c_ST_RUN  = 1'b0;
    localparam logic [0:0] c_ST_HOLD = 1'b1;

    logic [0:0]           r_state;
    logic [WIDTH-1:0]     r_pc;
    logic [WIDTH-1:0]     r_saved_pc;
    logic [CNT_WIDTH-1:0] r_redirect_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    logic [FETCH_WIDTH-1:0] w_lane_hit;
    logic [WIDTH-1:0]       w_lane_target [FETCH_WIDTH];
    logic                   w_taken;
    logic [c_ENQ_W-1:0]     w_taken_count;
    logic [WIDTH-1:0]       w_taken_target;
    logic                   w_pc_load;
    logic                   w_in_run;
    logic                   w_enq_valid;
    logic                   w_redirect_apply;

    // Per-lane redirect condition and unpacked target; a not-taken branch
    // does not hit and therefore falls through to the next lane.
    for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane
        assign w_lane_hit[gi]    = bus.lane_is_jal[gi]
                                 | (bus.lane_is_br[gi] & bus.lane_pred_taken[gi]);
        assign w_lane_target[gi] = bus.lane_target[gi*WIDTH +: WIDTH];
    end

    // Priority pick of the lowest hitting lane (scan high to low, last write wins)
    always_comb begin
        w_taken        = 1'b0;
        w_taken_count  = '0;
        w_taken_target = '0;
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (w_lane_hit[i]) begin
                w_taken        = 1'b1;
                w_taken_count  = c_ENQ_W'(i + 1);
                w_taken_target = w_lane_target[i];
            end
        end
    end

    assign w_pc_load        = bus.fetch_rdy & ~bus.iq_full;
    assign w_in_run         = (r_state == c_ST_RUN);
    // Groups returned in HOLD or alongside a flush are on the wrong path
    assign w_enq_valid      = w_pc_load & w_in_run & ~bus.flush_valid;
    // A predicted redirect only takes effect when the group itself is kept
    assign w_redirect_apply = w_enq_valid & w_taken;

    // PC, fetch state and saved flush target; flush > pending flush > taken > sequential
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_state    <= c_ST_RUN;
            r_saved_pc <= '0;
        end else if (w_pc_load) begin
            if (bus.flush_valid) begin
                r_pc    <= bus.flush_pc;
                r_state <= c_ST_RUN;
            end else if (r_state == c_ST_HOLD) begin
                r_pc    <= r_saved_pc;
                r_state <= c_ST_RUN;
            end else if (w_taken) begin
                r_pc    <= w_taken_target;
            end else begin
                r_pc    <= r_pc + c_PC_STEP;
            end
        end else if (bus.flush_valid) begin
            // The newest flush overwrites any one already waiting
            r_saved_pc <= bus.flush_pc;
            r_state    <= c_ST_HOLD;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_redirect_cnt <= '0;
            r_flush_cnt    <= '0;
        end else begin
            if (w_redirect_apply && (r_redirect_cnt != '1)) begin
                r_redirect_cnt <= r_redirect_cnt + 1'b1;
            end
            if (bus.flush_valid && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_out        = r_pc;
    assign bus.pc_load       = w_pc_load;
    assign bus.enq_valid     = w_enq_valid;
    assign bus.enq_count     = w_enq_valid ? (w_taken ? w_taken_count : c_ENQ_W'(FETCH_WIDTH))
                                           : '0;
    assign bus.redirect_pend = (r_state == c_ST_HOLD);
    assign bus.redirect_cnt  = r_redirect_cnt;
    assign bus.flush_cnt     = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_pc_unit
//  Description : Directed scoreboard bench for fetch_pc_unit (2-wide,
//                RESET_PC 0x60, 4-bit counters so saturation is reachable).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;
    localparam int W  = 32;
    localparam int FW = 2;
    localparam int CW = 4;

    localparam int SEL_PC    = 0;
    localparam int SEL_LOAD  = 1;
    localparam int SEL_ENQV  = 2;
    localparam int SEL_ENQC  = 3;
    localparam int SEL_PEND  = 4;
    localparam int SEL_RCNT  = 5;
    localparam int SEL_FCNT  = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fetch_pc_if #(.WIDTH(W), .FETCH_WIDTH(FW), .CNT_WIDTH(CW)) bus ();

    fetch_pc_unit #(
        .WIDTH       (W),
        .FETCH_WIDTH (FW),
        .RESET_PC    (32'h60),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            SEL_PC:   return bus.pc_out;
            SEL_LOAD: return 32'(bus.pc_load);
            SEL_ENQV: return 32'(bus.enq_valid);
            SEL_ENQC: return 32'(bus.enq_count);
            SEL_PEND: return 32'(bus.redirect_pend);
            SEL_RCNT: return 32'(bus.redirect_cnt);
            SEL_FCNT: return 32'(bus.flush_cnt);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] got;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = observe(e.sel);
            checks++;
            assert (got === e.val) else begin
                errors++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, got, e.val);
            end
        end
    endtask

    task automatic drive(input logic fr, input logic full,
                         input logic [FW-1:0] jal, input logic [FW-1:0] br,
                         input logic [FW-1:0] pt,
                         input logic [W-1:0] t0, input logic [W-1:0] t1,
                         input logic fv, input logic [W-1:0] fpc);
        bus.fetch_rdy       = fr;
        bus.iq_full         = full;
        bus.lane_is_jal     = jal;
        bus.lane_is_br      = br;
        bus.lane_pred_taken = pt;
        bus.lane_target     = {t1, t0};
        bus.flush_valid     = fv;
        bus.flush_pc        = fpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        expect_out("rst_pc", SEL_PC, 32'h60);
        expect_out("rst_pend", SEL_PEND, 32'h0);
        expect_out("rst_rcnt", SEL_RCNT, 32'h0);
        expect_out("rst_fcnt", SEL_FCNT, 32'h0);
        expect_out("rst_enqv", SEL_ENQV, 32'h0);
        expect_out("rst_enqc", SEL_ENQC, 32'h0);
        drain();

        // Sequential fetch: 0x60 -> 0x68 -> 0x70 -> 0x78 -> 0x80
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            expect_out("seq_pc", SEL_PC, 32'h60 + 32'(8 * i));
            expect_out("seq_load", SEL_LOAD, 32'h1);
            expect_out("seq_enqv", SEL_ENQV, 32'h1);
            expect_out("seq_enqc", SEL_ENQC, 32'h2);
            drain();
            tick();
        end
        expect_out("seq_pc_end", SEL_PC, 32'h80);
        drain();

        // Lane0 branch taken wins over lane1 jal
        drive(1'b1, 1'b0, 2'b10, 2'b01, 2'b01, 32'h200, 32'h300, 1'b0, 32'h0);
        #1;
        expect_out("br0_enqv", SEL_ENQV, 32'h1);
        expect_out("br0_enqc", SEL_ENQC, 32'h1);
        drain();
        tick();
        expect_out("br0_pc", SEL_PC, 32'h200);
        expect_out("br0_rcnt", SEL_RCNT, 32'h1);
        drain();

        // Flush together with pc_load: group dropped, taken lane ignored
        drive(1'b1, 1'b0, 2'b10, 2'b01, 2'b01, 32'h200, 32'h300, 1'b1, 32'h80);
        #1;
        expect_out("fl_load", SEL_LOAD, 32'h1);
        expect_out("fl_enqv", SEL_ENQV, 32'h0);
        expect_out("fl_enqc", SEL_ENQC, 32'h0);
        drain();
        tick();
        expect_out("fl_pc", SEL_PC, 32'h80);
        expect_out("fl_fcnt", SEL_FCNT, 32'h1);
        expect_out("fl_rcnt", SEL_RCNT, 32'h1);
        expect_out("fl_pend", SEL_PEND, 32'h0);
        drain();

        // Lane0 branch not taken falls through to lane1 jal
        drive(1'b1, 1'b0, 2'b10, 2'b01, 2'b00, 32'h200, 32'h300, 1'b0, 32'h0);
        #1;
        expect_out("jal1_enqv", SEL_ENQV, 32'h1);
        expect_out("jal1_enqc", SEL_ENQC, 32'h2);
        drain();
        tick();
        expect_out("jal1_pc", SEL_PC, 32'h300);
        expect_out("jal1_rcnt", SEL_RCNT, 32'h2);
        drain();

        // Flush while IQ full: latched, PC holds
        drive(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h400);
        #1;
        expect_out("hold_load", SEL_LOAD, 32'h0);
        expect_out("hold_enqv", SEL_ENQV, 32'h0);
        drain();
        tick();
        expect_out("hold_pend", SEL_PEND, 32'h1);
        expect_out("hold_pc", SEL_PC, 32'h300);
        expect_out("hold_fcnt", SEL_FCNT, 32'h2);
        drain();

        // Pending flush applied; a taken lane in this group is wrong path
        drive(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 32'h900, 32'h0, 1'b0, 32'h0);
        #1;
        expect_out("apply_enqv", SEL_ENQV, 32'h0);
        expect_out("apply_enqc", SEL_ENQC, 32'h0);
        expect_out("apply_pend_pre", SEL_PEND, 32'h1);
        drain();
        tick();
        expect_out("apply_pc", SEL_PC, 32'h400);
        expect_out("apply_pend", SEL_PEND, 32'h0);
        expect_out("apply_rcnt", SEL_RCNT, 32'h2);
        drain();

        // Two flushes while held: newest wins
        drive(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h600);
        tick();
        drive(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h500);
        tick();
        expect_out("nw_pend", SEL_PEND, 32'h1);
        expect_out("nw_fcnt", SEL_FCNT, 32'h4);
        expect_out("nw_pc_hold", SEL_PC, 32'h400);
        drain();
        drive(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        expect_out("nw_enqv", SEL_ENQV, 32'h0);
        drain();
        tick();
        expect_out("nw_pc", SEL_PC, 32'h500);
        expect_out("nw_pend_clr", SEL_PEND, 32'h0);
        drain();

        // Sequential wrap at the top of the address space
        drive(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        tick();
        expect_out("wrap_pc_pre", SEL_PC, 32'hFFFF_FFF8);
        expect_out("wrap_fcnt", SEL_FCNT, 32'h5);
        drain();
        drive(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        expect_out("wrap_enqc", SEL_ENQC, 32'h2);
        drain();
        tick();
        expect_out("wrap_pc", SEL_PC, 32'h0);
        drain();

        // Flush counter saturates at all-ones (4 bits -> 15)
        drive(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h700);
        repeat (12) tick();
        expect_out("sat_fcnt", SEL_FCNT, 32'hF);
        expect_out("sat_pend", SEL_PEND, 32'h1);
        drain();
        tick();
        expect_out("sat_fcnt_hold", SEL_FCNT, 32'hF);
        drain();

        // Asynchronous reset in HOLD discards the pending flush
        drive(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        expect_out("arst_pc", SEL_PC, 32'h60);
        expect_out("arst_pend", SEL_PEND, 32'h0);
        expect_out("arst_rcnt", SEL_RCNT, 32'h0);
        expect_out("arst_fcnt", SEL_FCNT, 32'h0);
        drain();
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        expect_out("post_enqv", SEL_ENQV, 32'h1);
        expect_out("post_enqc", SEL_ENQC, 32'h2);
        drain();
        tick();
        expect_out("post_pc", SEL_PC, 32'h68);
        expect_out("post_pend", SEL_PEND, 32'h0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
